apb_master_interface: RTL

APB4 requester (master) that turns single-cycle user transfer requests into IDLE/SETUP/ACCESS bus sequences toward two APB slave ports. It drives PSEL0/PSEL1, PENABLE, PADDR, PWRITE, PWDATA, PSTRB and PPROT, then waits on PREADY. It returns read data and a completion pulse to the user side. It is the initiator end of the APB link whose slaves are `apb_slave_interface` instances.

---
 rtl/apb_master_interface.sv | 138 +++++++++++++
 1 files changed

// File: rtl/apb_master_interface.sv
// APB4 requester: turns single-cycle user requests into SETUP/ACCESS sequences toward two slaves.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_interface #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int SEL_BIT        = ADDR_WIDTH - 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_strb,
    input  logic [2:0]            req_prot,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [2:0]            PPROT,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    output logic                  PSEL0,
    output logic                  PSEL1,
    output logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [1:0]            dbg_state
);

    // Handshake: a request is taken on a rising edge where req=1 and the bus is
    // either idle or finishing an ACCESS with PREADY=1; otherwise req is ignored.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    state_t state;
    logic   accept;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    assign dbg_state = state;
    assign accept    = req && ((state == IDLE) || ((state == ACCESS) && PREADY));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            PADDR       <= '0;
            PPROT       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            PSEL0       <= 1'b0;
            PSEL1       <= 1'b0;
            PENABLE     <= 1'b0;
            rdata       <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: ;
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        done <= 1'b1;
                        if (!PWRITE) rdata <= PRDATA;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        PSEL0   <= 1'b0;
                        PSEL1   <= 1'b0;
                        PENABLE <= 1'b0;
                        PSTRB   <= '0;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    // The limit-th PREADY=0 cycle ends the transfer with an error.
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        rdata       <= '0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        PSEL0       <= 1'b0;
                        PSEL1       <= 1'b0;
                        PENABLE     <= 1'b0;
                        PSTRB       <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    PSEL0   <= 1'b0;
                    PSEL1   <= 1'b0;
                    PENABLE <= 1'b0;
                    PSTRB   <= '0;
                end
            endcase

            // A new request overrides the return to IDLE, giving back-to-back transfers.
            if (accept) begin
                PADDR   <= req_addr;
                PPROT   <= req_prot;
                PWRITE  <= req_write;
                PWDATA  <= req_write ? req_wdata : '0;
                PSTRB   <= req_write ? req_strb : '0;
                PSEL0   <= ~req_addr[SEL_BIT];
                PSEL1   <= req_addr[SEL_BIT];
                PENABLE <= 1'b0;
                busy    <= 1'b1;
                state   <= SETUP;
            end
        end
    end

endmodule
